// File: rtl/z16_mmio_pkg.sv
// Z16 MMIO address map, UART status bit layout and UART TX FSM state encoding.
// Shared with the CPU's MMIO decode so both sides agree on every address.
package z16_mmio_pkg;

  localparam logic [15:0] MMIO_LED       = 16'h007A;
  localparam logic [15:0] MMIO_BUTTON    = 16'h007C;
  localparam logic [15:0] MMIO_UART_TX   = 16'h0078;
  localparam logic [15:0] MMIO_UART_STAT = 16'h0076;

  localparam int STAT_FULL = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

  typedef struct packed {
    logic ovf;
    logic busy;
    logic full;
  } uart_stat_t;

  // Place status flags at their architectural bit positions; upper bits read as zero.
  function automatic logic [15:0] uart_stat_word(input uart_stat_t s);
    logic [15:0] w;
    w            = '0;
    w[STAT_FULL] = s.full;
    w[STAT_BUSY] = s.busy;
    w[STAT_OVF]  = s.ovf;
    return w;
  endfunction

endpackage

// File: rtl/z16_sync_fifo.sv
// Generic synchronous FIFO: head visible combinationally, push/pop take effect at the edge.
// Push ignored while full, pop ignored while empty; simultaneous push+pop keeps count.
module z16_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic                   head_vld,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a pop in the same cycle cannot admit a push.
  assign full     = (cnt == CNT_FULL);
  assign head_vld = (cnt != '0);
  assign head_dat = mem[rd_ptr];
  assign count    = cnt;
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && head_vld;

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/z16_uart_tx.sv
// MMIO UART transmitter (8N1): CPU stores to ADDR_TX queue a byte; frame starts one edge after the push.
// No backpressure to the CPU: a store while the FIFO is full is dropped and sets sticky overflow.
module z16_uart_tx
  import z16_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 234,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] ADDR_TX      = MMIO_UART_TX,
  parameter logic [15:0] ADDR_STAT    = MMIO_UART_STAT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic        i_wen,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_hit,
  output logic        o_tx
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'd7;

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic           ovf_q;

  logic           wr_tx;
  logic           wr_stat;
  logic           ovf_set;
  logic           baud_last;
  logic           busy;
  uart_stat_t     stat;

  logic           fifo_pop;
  logic           fifo_head_vld;
  logic [7:0]     fifo_head_dat;
  logic           fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic           unused_bits;

  assign wr_tx   = i_wen && (i_addr == ADDR_TX);
  assign wr_stat = i_wen && (i_addr == ADDR_STAT);
  assign ovf_set = wr_tx && fifo_full;

  z16_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push_vld (wr_tx),
    .push_dat (i_wdata[7:0]),
    .pop_rdy  (fifo_pop),
    .head_vld (fifo_head_vld),
    .head_dat (fifo_head_dat),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // Upper store byte and the occupancy count are not needed by the transmitter.
  assign unused_bits = ^{i_wdata[15:8], fifo_count};

  // Overflow is sticky; a same-cycle overflow beats the clearing write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (wr_stat) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign baud_last = (baud_q == BAUD_LAST);

  // tx_d is the line level for the cycle after the edge, so o_tx stays a plain flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (fifo_head_vld) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head_dat;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = TX_START;
          tx_d     = 1'b0;
        end
      end

      TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      TX_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (fifo_head_vld) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head_dat;
            bit_d    = '0;
            state_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign busy      = (state_q != TX_IDLE) || fifo_head_vld;
  assign stat.ovf  = ovf_q;
  assign stat.busy = busy;
  assign stat.full = fifo_full;

  assign o_hit   = (i_addr == ADDR_STAT);
  assign o_rdata = o_hit ? uart_stat_word(stat) : 16'h0000;
  assign o_tx    = tx_q;

endmodule
